inst_encoder_loader: RTL and testbench
======================================

// Module: inst_encoder_loader
// PURPOSE
//  Inverse of the instruction decoder: accepts abstract op requests (kind, regs, imm) over a
//  valid/ready handshake, encodes them into standard RV32I 32-bit words and writes them to
//  consecutive instruction-memory addresses. Used by the boot/test path to build programs
//  in IMEM; covers the decoder's op set: ADD SUB OR AND ADDI LW SW BEQ.
// PARAMETERS
//  ADDR_W  8    IMEM word-address width
//  DEPTH   256  max words loaded before FULL (DEPTH <= 2**ADDR_W)
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  reset       in   1       reset, synchronous, active-low
//  clear       in   1       restart load: addr/count/err to 0, state LOAD
//  op_valid    in   1       request valid
//  op_ready    out  1       block can accept request this cycle
//  op_kind     in   3       0 ADD,1 SUB,2 OR,3 AND,4 ADDI,5 LW,6 SW,7 BEQ
//  rd/rs1/rs2  in   5 each  register indices (unused fields ignored per kind)
//  imm         in   32      signed immediate (byte offset for BEQ)
//  imem_we     out  1       IMEM write strobe, one cycle per word
//  imem_addr   out  ADDR_W  IMEM word address
//  imem_wdata  out  32      encoded instruction
//  prog_count  out  ADDR_W+1 words accepted-and-valid since reset/clear
//  full        out  1       prog_count == DEPTH
//  err         out  1       sticky encode error
//  err_code    out  2       0 none,1 imm out of range,2 BEQ imm odd
// BEHAVIOUR
//  Reset (reset==0 at edge): state LOAD; imem_we=0, imem_addr=0, imem_wdata=0, prog_count=0,
//   full=0, err=0, err_code=0. Any in-flight write is dropped (no imem_we after reset).
//  FSM: LOAD -> FULL when accepted op makes prog_count==DEPTH; LOAD -> ERR on bad imm;
//   FULL/ERR -> LOAD only on clear. op_ready = (state==LOAD) && !clear.
//  Accept = op_valid && op_ready at edge N. Encoding registered: imem_we=1 with imem_wdata
//   and imem_addr valid during cycle N+1 only (latency 1). Back-to-back accepts give one
//   write per cycle. imem_addr for k-th valid word = k (0-based); prog_count increments at N.
//  Encoding (opcode/funct3/funct7, standard RV32I fields):
//   R: 0110011, f3 ADD/SUB 000, OR 110, AND 111; f7 0100000 for SUB, else 0. rd,rs1,rs2 used.
//   ADDI 0010011 f3 000, LW 0000011 f3 010: inst[31:20]=imm[11:0]; rs2 ignored.
//   SW 0100011 f3 010: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; rd ignored.
//   BEQ 1100011 f3 000: inst[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
//  Range checks: I/S kinds imm in [-2048,2047]; BEQ imm in [-4096,4094] and imm[0]==0.
//   Failing op is consumed (handshake completes) but not written, prog_count unchanged;
//   err=1, err_code set (range checked before odd; range wins); state ERR. R kinds ignore imm.
//  clear: takes effect at edge, priority over op_valid (no accept that cycle); a write
//   registered in the previous cycle still completes at its old address in the clear cycle.
//  reset has priority over clear and op_valid.
// TESTING
//  ADD rd3 rs1 1 rs2 2 -> imem_we next cycle, addr 0, wdata 0x002081B3; SUB same -> 0x402081B3
//  ADDI rd5 rs1 0 imm -1 -> 0xFFF00293; LW rd6 rs1 2 imm 8 -> 0x00812303
//  SW rs2 6 rs1 2 imm 12 -> 0x00612623; BEQ rs1 1 rs2 2 imm -8 -> 0xFE208CE3
//  ADDI imm 2048 -> no imem_we, err=1, err_code=1, op_ready=0 until clear; BEQ imm 5 -> code 2
//  DEPTH=4: 4 back-to-back ops -> addrs 0..3, full=1, op_ready=0; clear -> next op at addr 0
//  reset low the cycle after an accept -> no imem_we, all outputs 0 next cycle

Source files
------------

// File: rtl/inst_encoder_loader.sv
// -----------------------------------------------------------------------------
// inst_encoder_loader
//   Takes abstract op requests (kind, registers, immediate) over a valid/ready
//   handshake, encodes each one into a standard RV32I instruction word and
//   writes it to consecutive instruction-memory word addresses. The boot/test
//   path uses it to build programs in IMEM. Supported ops match the decoder:
//   ADD SUB OR AND ADDI LW SW BEQ.
//
// Parameters
//   ADDR_W      IMEM word-address width
//   DEPTH       words accepted before the loader reports full (<= 2**ADDR_W)
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-low reset (highest priority)
//   clear       restart loading at address 0, drop a sticky error
//   op_valid    request valid
//   op_ready    request can be accepted this cycle
//   op_kind     0 ADD,1 SUB,2 OR,3 AND,4 ADDI,5 LW,6 SW,7 BEQ
//   rd/rs1/rs2  register indices (fields not used by a kind are ignored)
//   imm         signed immediate (byte offset for BEQ)
//   imem_we     IMEM write strobe, one cycle per encoded word
//   imem_addr   IMEM word address of the write
//   imem_wdata  encoded instruction word
//   prog_count  words accepted and written since reset/clear
//   full        prog_count has reached DEPTH
//   err         sticky encode error
//   err_code    0 none, 1 immediate out of range, 2 BEQ offset odd
// -----------------------------------------------------------------------------
module inst_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_kind,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   prog_count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  // Loader states
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // Op kinds
  localparam logic [2:0] K_ADD  = 3'd0;
  localparam logic [2:0] K_SUB  = 3'd1;
  localparam logic [2:0] K_OR   = 3'd2;
  localparam logic [2:0] K_AND  = 3'd3;
  localparam logic [2:0] K_ADDI = 3'd4;
  localparam logic [2:0] K_LW   = 3'd5;
  localparam logic [2:0] K_SW   = 3'd6;
  localparam logic [2:0] K_BEQ  = 3'd7;

  // RV32I opcodes and function fields
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_OPI  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STOR = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BEQ   = 3'b000;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_SUB   = 7'b0100000;

  // Error codes
  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_RANGE = 2'd1;
  localparam logic [1:0] E_ODD   = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  // R-type: funct7 | rs2 | rs1 | funct3 | rd | opcode
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2);
    return {f7, s2, s1, f3, d, OPC_R};
  endfunction

  // I-type: imm[11:0] | rs1 | funct3 | rd | opcode
  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [4:0] s1,
                                        input logic [11:0] i12);
    return {i12, s1, f3, d, opc};
  endfunction

  // S-type: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode
  function automatic logic [31:0] enc_s(input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [11:0] i12);
    return {i12[11:5], s2, s1, F3_WORD, i12[4:0], OPC_STOR};
  endfunction

  // B-type. 'off' is imm[12:1] (bit 0 of a branch offset is never encoded),
  // so off[11]=imm[12], off[10]=imm[11], off[9:4]=imm[10:5], off[3:0]=imm[4:1].
  function automatic logic [31:0] enc_b(input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [11:0] off);
    return {off[11], off[9:4], s2, s1, F3_BEQ, off[3:0], off[10], OPC_BR};
  endfunction

  // True when the upper bits are a pure sign extension (all 0s or all 1s).
  function automatic logic sext_ok(input logic [20:0] hi);
    return (hi == {21{1'b0}}) || (hi == {21{1'b1}});
  endfunction

  logic [1:0]        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_err;
  logic [1:0]        r_code;

  logic              w_accept;
  logic              w_i_range;
  logic              w_b_range;
  logic [31:0]       w_enc;
  logic [1:0]        w_code;
  logic [ADDR_W:0]   w_count_nxt;

  assign op_ready    = (r_state == ST_LOAD) && !clear;
  assign w_accept    = op_valid && op_ready;
  assign w_count_nxt = r_count + ONE_C;

  // 12-bit signed: [-2048, 2047]. Branch: 13-bit signed minus 4095, which is
  // odd anyway but must report as out of range since range outranks oddness.
  assign w_i_range = sext_ok(imm[31:11]);
  assign w_b_range = sext_ok({imm[31:12], imm[12]}) && (imm != 32'h0000_0FFF);

  // Encode the presented op and classify its immediate.
  always_comb begin
    w_enc  = 32'h0000_0000;
    w_code = E_NONE;
    case (op_kind)
      K_ADD:  w_enc = enc_r(F7_BASE, F3_ADD, rd, rs1, rs2);
      K_SUB:  w_enc = enc_r(F7_SUB,  F3_ADD, rd, rs1, rs2);
      K_OR:   w_enc = enc_r(F7_BASE, F3_OR,  rd, rs1, rs2);
      K_AND:  w_enc = enc_r(F7_BASE, F3_AND, rd, rs1, rs2);
      K_ADDI: begin
        w_enc = enc_i(OPC_OPI, F3_ADD, rd, rs1, imm[11:0]);
        if (!w_i_range) begin
          w_code = E_RANGE;
        end else begin
          w_code = E_NONE;
        end
      end
      K_LW: begin
        w_enc = enc_i(OPC_LOAD, F3_WORD, rd, rs1, imm[11:0]);
        if (!w_i_range) begin
          w_code = E_RANGE;
        end else begin
          w_code = E_NONE;
        end
      end
      K_SW: begin
        w_enc = enc_s(rs1, rs2, imm[11:0]);
        if (!w_i_range) begin
          w_code = E_RANGE;
        end else begin
          w_code = E_NONE;
        end
      end
      K_BEQ: begin
        w_enc = enc_b(rs1, rs2, imm[12:1]);
        if (!w_b_range) begin
          w_code = E_RANGE;
        end else if (imm[0]) begin
          w_code = E_ODD;
        end else begin
          w_code = E_NONE;
        end
      end
      default: begin
        w_enc  = 32'h0000_0000;
        w_code = E_NONE;
      end
    endcase
  end

  // Loader FSM, write port and status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_LOAD;
      r_we    <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= 32'h0000_0000;
      r_count <= {(ADDR_W+1){1'b0}};
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= E_NONE;
    end else if (clear) begin
      // A word registered last cycle has already been presented this cycle.
      r_state <= ST_LOAD;
      r_we    <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_count <= {(ADDR_W+1){1'b0}};
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= E_NONE;
    end else if (w_accept) begin
      if (w_code != E_NONE) begin
        // Bad op is consumed but never written.
        r_state <= ST_ERR;
        r_we    <= 1'b0;
        r_err   <= 1'b1;
        r_code  <= w_code;
      end else begin
        r_we    <= 1'b1;
        r_addr  <= r_count[ADDR_W-1:0];
        r_wdata <= w_enc;
        r_count <= w_count_nxt;
        if (w_count_nxt == DEPTH_C) begin
          r_state <= ST_FULL;
          r_full  <= 1'b1;
        end else begin
          r_state <= ST_LOAD;
          r_full  <= 1'b0;
        end
      end
    end else begin
      r_we <= 1'b0;
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign prog_count = r_count;
  assign full       = r_full;
  assign err        = r_err;
  assign err_code   = r_code;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder_loader
//   Self-checking bench for inst_encoder_loader (DEPTH=4). Directed scenarios
//   use the known RV32I encodings; the random scenario compares every output
//   each cycle against a word-level reference model built from field
//   arithmetic and simple counters.
// -----------------------------------------------------------------------------
module tb_inst_encoder_loader;

  localparam int AW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset, clear, op_valid;
  logic [2:0]    op_kind;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm;
  logic          op_ready, imem_we, full, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   prog_count;
  logic [1:0]    err_code;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          m_count;
  bit          m_err;
  int          m_code;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  inst_encoder_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .clear(clear), .op_valid(op_valid), .op_ready(op_ready),
    .op_kind(op_kind), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .prog_count(prog_count), .full(full), .err(err), .err_code(err_code)
  );

  function automatic logic [31:0] ref_enc(input logic [2:0] k, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [31:0] im);
    logic [31:0] w;
    logic [31:0] f3;
    logic [31:0] f7;
    w = 32'd0;
    case (k)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        f3 = (k == 3'd2) ? 32'd6 : ((k == 3'd3) ? 32'd7 : 32'd0);
        f7 = (k == 3'd1) ? 32'd32 : 32'd0;
        w = 32'h33 + (32'(d) << 7) + (f3 << 12) + (32'(s1) << 15) + (32'(s2) << 20) + (f7 << 25);
      end
      3'd4: w = 32'h13 + (32'(d) << 7) + (32'(s1) << 15) + ((im & 32'hFFF) << 20);
      3'd5: w = 32'h03 + (32'(d) << 7) + (32'd2 << 12) + (32'(s1) << 15) + ((im & 32'hFFF) << 20);
      3'd6: w = 32'h23 + ((im & 32'h1F) << 7) + (32'd2 << 12) + (32'(s1) << 15) +
                (32'(s2) << 20) + (((im >> 5) & 32'h7F) << 25);
      default: w = 32'h63 + (((im >> 11) & 32'd1) << 7) + (((im >> 1) & 32'hF) << 8) +
                   (32'(s1) << 15) + (32'(s2) << 20) + (((im >> 5) & 32'h3F) << 25) +
                   (((im >> 12) & 32'd1) << 31);
    endcase
    return w;
  endfunction

  function automatic int ref_code(input logic [2:0] k, input logic [31:0] im);
    int si;
    si = $signed(im);
    if (k >= 3'd4 && k <= 3'd6) return (si < -2048 || si > 2047) ? 1 : 0;
    if (k == 3'd7) begin
      if (si < -4096 || si > 4094) return 1;
      if ((si % 2) != 0) return 2;
    end
    return 0;
  endfunction

  // one clock: drive at negedge, advance the model, sample 1 time unit after posedge
  task automatic cycle(input bit rst_n, input bit v, input bit clr, input logic [2:0] k,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    int c;
    @(negedge clk);
    reset = rst_n; op_valid = v; clear = clr; op_kind = k;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    if (!rst_n) begin
      m_count = 0; m_err = 0; m_code = 0; m_we = 0; m_addr = 0; m_wdata = 32'd0;
    end else if (clr) begin
      m_count = 0; m_err = 0; m_code = 0; m_we = 0;
    end else if (v && !m_err && m_count != DP) begin
      c = ref_code(k, im);
      if (c != 0) begin
        m_err = 1; m_code = c; m_we = 0;
      end else begin
        m_we = 1; m_addr = m_count; m_wdata = ref_enc(k, d, s1, s2, im); m_count++;
      end
    end else begin
      m_we = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  task automatic do_clear();
    cycle(1'b1, 1'b0, 1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    idle();
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    idle();
    n_tests++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b0, 8'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_wr: got we=%b addr=%0d data=%h required 0/0/0", imem_we, imem_addr, imem_wdata);
    end
    n_tests++;
    if ({prog_count, full, err, err_code} !== {9'd0, 1'b0, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL reset_status: got cnt=%0d full=%b err=%b code=%0d required 0", prog_count, full, err, err_code);
    end
    n_tests++;
    if (op_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", op_ready);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] exp_w [6] = '{32'h002081B3, 32'h402081B3, 32'hFFF00293,
                               32'h00812303, 32'h00612623, 32'hFE208CE3};
    logic [7:0]  exp_a [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: cycle(1'b1, 1'b1, 1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        1: cycle(1'b1, 1'b1, 1'b0, 3'd1, 5'd3, 5'd1, 5'd2, 32'd0);
        2: cycle(1'b1, 1'b1, 1'b0, 3'd4, 5'd5, 5'd0, 5'd9, 32'hFFFF_FFFF);
        3: cycle(1'b1, 1'b1, 1'b0, 3'd5, 5'd6, 5'd2, 5'd9, 32'd8);
        4: cycle(1'b1, 1'b1, 1'b0, 3'd6, 5'd31, 5'd2, 5'd6, 32'd12);
        default: cycle(1'b1, 1'b1, 1'b0, 3'd7, 5'd31, 5'd1, 5'd2, 32'hFFFF_FFF8);
      endcase
      n_tests++;
      if ({imem_we, imem_addr, imem_wdata} !== {1'b1, exp_a[i], exp_w[i]}) begin
        n_fail++; $display("FAIL vec%0d: got we=%b addr=%0d data=%h required 1/%0d/%h",
                           i, imem_we, imem_addr, imem_wdata, exp_a[i], exp_w[i]);
      end
      if (i == 3) begin
        n_tests++;
        if ({full, op_ready, prog_count} !== {1'b1, 1'b0, 9'd4}) begin
          n_fail++; $display("FAIL full_flag: got full=%b ready=%b cnt=%0d required 1/0/4", full, op_ready, prog_count);
        end
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        n_tests++;
        if ({imem_we, prog_count} !== {1'b0, 9'd4}) begin
          n_fail++; $display("FAIL full_block: got we=%b cnt=%0d required 0/4", imem_we, prog_count);
        end
        do_clear();
        n_tests++;
        if ({full, op_ready, prog_count} !== {1'b0, 1'b1, 9'd0}) begin
          n_fail++; $display("FAIL clear_full: got full=%b ready=%b cnt=%0d required 0/1/0", full, op_ready, prog_count);
        end
      end
    end
    idle();
    do_clear();
  endtask

  task automatic test_errors();
    cycle(1'b1, 1'b1, 1'b0, 3'd4, 5'd1, 5'd1, 5'd0, 32'd2048);
    n_tests++;
    if ({imem_we, err, err_code, op_ready, prog_count} !== {1'b0, 1'b1, 2'd1, 1'b0, 9'd0}) begin
      n_fail++; $display("FAIL addi_range: got we=%b err=%b code=%0d ready=%b cnt=%0d required 0/1/1/0/0",
                         imem_we, err, err_code, op_ready, prog_count);
    end
    cycle(1'b1, 1'b1, 1'b0, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    n_tests++;
    if ({imem_we, err, op_ready} !== {1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL err_sticky: got we=%b err=%b ready=%b required 0/1/0", imem_we, err, op_ready);
    end
    do_clear();
    cycle(1'b1, 1'b1, 1'b0, 3'd7, 5'd0, 5'd1, 5'd2, 32'd5);
    n_tests++;
    if ({imem_we, err, err_code} !== {1'b0, 1'b1, 2'd2}) begin
      n_fail++; $display("FAIL beq_odd: got we=%b err=%b code=%0d required 0/1/2", imem_we, err, err_code);
    end
    do_clear();
    cycle(1'b1, 1'b1, 1'b0, 3'd7, 5'd0, 5'd1, 5'd2, 32'd4095);
    n_tests++;
    if (err_code !== 2'd1) begin
      n_fail++; $display("FAIL beq_range_wins: got code=%0d required 1", err_code);
    end
    do_clear();
    cycle(1'b1, 1'b1, 1'b0, 3'd7, 5'd0, 5'd1, 5'd2, 32'd4094);
    cycle(1'b1, 1'b1, 1'b0, 3'd6, 5'd0, 5'd1, 5'd2, 32'hFFFF_F800);
    n_tests++;
    if ({imem_we, imem_addr, err, prog_count} !== {1'b1, 8'd1, 1'b0, 9'd2}) begin
      n_fail++; $display("FAIL edge_ok: got we=%b addr=%0d err=%b cnt=%0d required 1/1/0/2", imem_we, imem_addr, err, prog_count);
    end
    cycle(1'b1, 1'b1, 1'b0, 3'd5, 5'd0, 5'd1, 5'd2, 32'hFFFF_F7FF);
    n_tests++;
    if ({imem_we, err_code, prog_count} !== {1'b0, 2'd1, 9'd2}) begin
      n_fail++; $display("FAIL lw_range: got we=%b code=%0d cnt=%0d required 0/1/2", imem_we, err_code, prog_count);
    end
    do_clear();
  endtask

  task automatic test_clear_inflight();
    cycle(1'b1, 1'b1, 1'b0, 3'd2, 5'd1, 5'd2, 5'd3, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 3'd3, 5'd4, 5'd5, 5'd6, 32'd0);
    @(negedge clk);
    clear = 1'b1; op_valid = 1'b1;
    #1;
    n_tests++;
    if ({imem_we, imem_addr} !== {1'b1, 8'd1}) begin
      n_fail++; $display("FAIL clear_inflight: got we=%b addr=%0d required 1/1", imem_we, imem_addr);
    end
    cycle(1'b1, 1'b1, 1'b1, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    n_tests++;
    if ({imem_we, prog_count} !== {1'b0, 9'd0}) begin
      n_fail++; $display("FAIL clear_prio: got we=%b cnt=%0d required 0/0", imem_we, prog_count);
    end
    cycle(1'b1, 1'b1, 1'b0, 3'd0, 5'd7, 5'd8, 5'd9, 32'd0);
    n_tests++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'd0, 32'h009403B3}) begin
      n_fail++; $display("FAIL after_clear: got we=%b addr=%0d data=%h required 1/0/009403b3", imem_we, imem_addr, imem_wdata);
    end
  endtask

  task automatic test_reset_inflight();
    cycle(1'b1, 1'b1, 1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 3'd1, 5'd3, 5'd1, 5'd2, 32'd0);
    n_tests++;
    if ({imem_we, imem_addr, imem_wdata, prog_count, full, err, err_code} !== 46'd0) begin
      n_fail++; $display("FAIL reset_inflight: got we=%b addr=%0d data=%h cnt=%0d required all 0",
                         imem_we, imem_addr, imem_wdata, prog_count);
    end
    idle();
  endtask

  function automatic logic [31:0] rand_imm(input logic [2:0] k);
    int          bl [8] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095};
    int          sel;
    logic [31:0] v;
    sel = $urandom_range(0, 9);
    if (sel <= 5) begin
      if (k == 3'd7) begin
        v = 32'($urandom_range(0, 8191)) - 32'd4096;
        if (sel < 5) v = v & 32'hFFFF_FFFE;
      end else begin
        v = 32'($urandom_range(0, 4095)) - 32'd2048;
      end
    end else if (sel == 6) begin
      v = bl[$urandom_range(0, 7)];
    end else begin
      v = $urandom;
    end
    return v;
  endfunction

  task automatic test_random();
    bit          rn, v, c;
    logic [2:0]  k;
    logic [31:0] im;
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 99) != 0);
      if (m_err || m_count == DP) c = ($urandom_range(0, 3) == 0);
      else c = ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 9) < 7);
      k  = 3'($urandom_range(0, 7));
      im = rand_imm(k);
      cycle(rn, v, c, k, 5'($urandom), 5'($urandom), 5'($urandom), im);
      n_tests++;
      if (imem_we !== m_we || (m_we && (imem_addr !== 8'(m_addr) || imem_wdata !== m_wdata))) begin
        n_fail++; $display("FAIL rnd_write @%0d: got we=%b addr=%0d data=%h required %b/%0d/%h",
                           i, imem_we, imem_addr, imem_wdata, m_we, m_addr, m_wdata);
      end
      n_tests++;
      if ({prog_count, full, err, err_code, op_ready} !==
          {9'(m_count), (m_count == DP), m_err, 2'(m_code), (!m_err && m_count != DP && !c)}) begin
        n_fail++; $display("FAIL rnd_status @%0d: got cnt=%0d full=%b err=%b code=%0d ready=%b required cnt=%0d err=%b code=%0d",
                           i, prog_count, full, err, err_code, op_ready, m_count, m_err, m_code);
      end
    end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; op_valid = 1'b0; op_kind = 3'd0;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;
    test_reset();
    test_vectors();
    test_errors();
    test_clear_inflight();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
